// File: rtl/mini_ctrl_seq.sv
// Multi-cycle instruction sequencer: IDLE -> DECODE -> EXEC (x EXEC_CYCLES) -> WB.
// Optional retired-instruction counter enabled by defining MINI_CTRL_RETIRE_CNT_EN.
//
// state  | meaning
// IDLE   | waiting for an instruction, instr_ready high unless flush
// DECODE | IR fields presented, exec counter cleared
// EXEC   | counting EXEC_CYCLES cycles
// WB     | rf_we and done asserted for one cycle
module mini_ctrl_seq #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  input  logic       flush,
  output logic       instr_ready,
  output logic [1:0] alu_sel,
  output logic [1:0] rf_ra,
  output logic [1:0] rf_rb,
  output logic [1:0] rf_wa,
  output logic       rf_we,
  output logic       done,
  output logic       busy
`ifdef MINI_CTRL_RETIRE_CNT_EN
  ,
  output logic [7:0] retired_cnt
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_WB     = 2'd3;

  localparam logic [1:0] EXEC_LAST = 2'(EXEC_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic [1:0] cnt_q, cnt_d;
  logic       accept;

  assign instr_ready = (state_q == S_IDLE) && !flush;
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        cnt_d   = 2'd0;
        state_d = flush ? S_IDLE : S_EXEC;
      end
      S_EXEC: begin
        cnt_d = cnt_q + 2'd1;
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == EXEC_LAST) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ir_q    <= 8'h00;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Field outputs come straight from IR so they hold their value through IDLE.
  assign alu_sel = ir_q[7:6];
  assign rf_wa   = ir_q[5:4];
  assign rf_ra   = ir_q[3:2];
  assign rf_rb   = ir_q[1:0];

  assign rf_we = (state_q == S_WB);
  assign done  = (state_q == S_WB);
  assign busy  = (state_q != S_IDLE);

`ifdef MINI_CTRL_RETIRE_CNT_EN
  logic [7:0] ret_q, ret_d;

  // A flush sampled in WB still retires, since rf_we fired in that cycle.
  always_comb begin
    ret_d = ret_q;
    if (state_q == S_WB) begin
      ret_d = ret_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_q <= 8'h00;
    end else begin
      ret_q <= ret_d;
    end
  end

  assign retired_cnt = ret_q;
`endif

endmodule

// File: doc/mini_ctrl_seq.md
# mini_ctrl_seq

Multi-cycle instruction sequencer for the mini processor. It accepts one 8-bit instruction per valid/ready handshake and decodes it into the 2-bit ALU result-select code that drives the 4-input result mux. It also produces the register-file read addresses, write address and write enable. It walks each instruction through DECODE, EXEC and WB, and signals retirement with a one-cycle `done` pulse.

## Interface
- `EXEC_CYCLES`, default 1: cycles spent in EXEC; legal range 1..4.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `instr_valid`  input  1  instruction offered.
- `instr`  input  8  instruction fields:
  - [7:6] op: 00 add, 01 sub, 10 and, 11 or.
  - [5:4] rd, [3:2] rs, [1:0] rt.
- `flush`  input  1  abort the in-flight instruction; synchronous.
- `instr_ready`  output  1  sequencer can accept an instruction.
- `alu_sel`  output  2  result-mux select, equal to the latched op.
- `rf_ra`  output  2  read address A, equal to the latched rs.
- `rf_rb`  output  2  read address B, equal to the latched rt.
- `rf_wa`  output  2  write address, equal to the latched rd.
- `rf_we`  output  1  register-file write enable.
- `done`  output  1  one-cycle retire pulse.
- `busy`  output  1  state is not IDLE.
- `retired_cnt`  output  8  retired-instruction count; present only with `MINI_CTRL_RETIRE_CNT_EN`.

## Operation
- **States:** IDLE, DECODE, EXEC, WB, held in a 2-bit state register.
- **Ready and accept:**
  - `instr_ready` = (state==IDLE) && !flush. It is combinational.
  - Accept occurs when `instr_valid && instr_ready`.
- **IDLE:**
  - On accept, latch `instr` into the instruction register (IR) and go to DECODE.
  - Without accept, stay in IDLE.
- **DECODE:** lasts one cycle, then goes to EXEC. The exec counter loads 0.
- **EXEC:**
  - The counter increments each cycle.
  - Leave for WB in the cycle where counter == `EXEC_CYCLES`-1.
- **WB:** lasts one cycle.
  - `rf_we`=1 and `done`=1 in this cycle.
  - Next state is IDLE.
- **Field outputs:** `alu_sel`, `rf_ra`, `rf_rb` and `rf_wa` are driven directly from IR fields.
  - They are stable from DECODE through WB.
  - They hold their last value in IDLE.
- `rf_we` and `done` are high only in WB.
- **Flush:**
  - When `flush`=1 in DECODE, EXEC or WB, the next state is IDLE.
  - The IR is unchanged.
  - If flush is sampled in WB, `rf_we`/`done` still assert during that WB cycle, because they are combinational outputs of the state.
  - Flush in IDLE blocks accept and has no other effect.
- `instr_valid` outside IDLE is ignored; the source must hold its data until accepted.
- An `EXEC_CYCLES` value outside 1..4 is a configuration error and its behaviour is unspecified.

## Timing
- **Reset** (asynchronous assert; deassert is synchronous to `clk`):
  - state=IDLE, IR=8'h00, exec counter=0.
  - `alu_sel`=`rf_ra`=`rf_rb`=`rf_wa`=0.
  - `rf_we`=0, `done`=0, `busy`=0.
  - `instr_ready`=1 (when `flush`=0).
  - `retired_cnt`=0.
- **Reset mid-instruction:** the sequencer returns to IDLE immediately. No `rf_we` and no `done` occur for the aborted instruction.
- **Per-instruction timeline,** with accept at edge N:
  - DECODE in cycle N+1.
  - EXEC in cycles N+2 .. N+1+`EXEC_CYCLES`.
  - WB in cycle N+2+`EXEC_CYCLES`.
  - IDLE in the following cycle.
- **Accept-to-retire latency** is `EXEC_CYCLES`+2 cycles.
- **Minimum initiation interval** is `EXEC_CYCLES`+3 cycles; there is no back-to-back accept from WB.
- `busy` is registered state decode: high from DECODE through WB.

## Configuration
- **With `MINI_CTRL_RETIRE_CNT_EN` defined:**
  - `retired_cnt` port exists.
  - Increments by 1 at the end of every WB cycle.
  - Wraps 8'hFF to 8'h00.
  - Cleared only by reset.
- **Without it:** the port and its counter logic are absent. All other behaviour is identical.

## Test plan
- **Reset:** assert `rst_n`=0 mid-EXEC.
  - All outputs go to reset values without waiting for a clock edge.
  - `instr_ready`=1 after reset is released.
  - No `done` pulse occurs.
- **Single instruction,** `EXEC_CYCLES`=1, instr=8'b01_10_01_11:
  - `alu_sel`=01, `rf_ra`=01, `rf_rb`=11, `rf_wa`=10.
  - `rf_we`/`done` high exactly in cycle N+3.
  - Ready again in cycle N+4.
- **All four ops back-to-back,** `EXEC_CYCLES`=3:
  - `alu_sel` sequence is 00, 01, 10, 11.
  - Each retires 5 cycles after accept.
  - Accepts are spaced 6 cycles apart.
- **Flush:**
  - Flush in EXEC cycle 2 of 3: returns to IDLE next cycle, no `rf_we`, no `done`.
  - Flush with `instr_valid`=1 in IDLE: the instruction is not accepted.
- **Valid while busy:** change `instr` during EXEC. The IR and outputs keep the original fields.
- **Counter** (`MINI_CTRL_RETIRE_CNT_EN`):
  - 257 retirements yield `retired_cnt`=8'h01.
  - Flushed instructions do not count.
